// File: rtl/deskew_axil_pkg.sv
// ============================================================================
// Module      : deskew_axil_pkg
// Description : Shared types and constants for the deskew AXI-Lite initiator.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package deskew_axil_pkg;

    localparam int DEFAULT_ADDR_WIDTH     = 8;
    localparam int DEFAULT_DATA_WIDTH     = 32;
    localparam int DEFAULT_TIMEOUT_CYCLES = 1024;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        WR_REQ  = 3'd1,
        WR_RESP = 3'd2,
        RD_REQ  = 3'd3,
        RD_DATA = 3'd4,
        RSP     = 3'd5
    } state_t;

    // Busy states are the ones in which the slave owes us a handshake.
    function automatic logic is_busy(input state_t s);
        return (s == WR_REQ) || (s == WR_RESP) || (s == RD_REQ) || (s == RD_DATA);
    endfunction

endpackage

`default_nettype wire

// File: rtl/deskew_axil_watchdog.sv
// ============================================================================
// Module      : deskew_axil_watchdog
// Description : Saturating transaction watchdog; pulses expire_o once per run.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module deskew_axil_watchdog
    import deskew_axil_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
    input  logic clk,
    input  logic resetn,
    input  logic clear_i,
    input  logic en_i,
    output logic expire_o
);

    localparam int              CNT_W    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             w_sat;

    assign w_sat = (cnt_q == CNT_MAX);

    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (en_i && !w_sat) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Fires on the increment that lands on the limit; saturation keeps it single-shot.
    assign expire_o = en_i && !clear_i && (cnt_q == CNT_LAST);

endmodule

`default_nettype wire

// File: rtl/deskew_axil_master.sv
// ============================================================================
// Module      : deskew_axil_master
// Description : Command/response to AXI-Lite initiator, one transaction at a time.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module deskew_axil_master
    import deskew_axil_pkg::*;
#(
    parameter int REG_ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
    parameter int REG_DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
    input  logic                      clk,
    input  logic                      resetn,
    input  logic                      cmd_valid,
    output logic                      cmd_ready,
    input  logic                      cmd_write,
    input  logic [REG_ADDR_WIDTH-1:0] cmd_addr,
    input  logic [REG_DATA_WIDTH-1:0] cmd_wdata,
    output logic                      rsp_valid,
    input  logic                      rsp_ready,
    output logic                      rsp_write,
    output logic [REG_DATA_WIDTH-1:0] rsp_rdata,
    output logic [1:0]                rsp_resp,
    output logic                      timeout_flag,
    output logic [REG_ADDR_WIDTH-1:0] axis_waddr,
    output logic                      axis_waddr_valid,
    input  logic                      axis_waddr_ready,
    output logic [REG_DATA_WIDTH-1:0] axis_wdata,
    output logic                      axis_wdata_valid,
    input  logic                      axis_wdata_ready,
    input  logic [1:0]                axis_bresp,
    input  logic                      axis_bresp_valid,
    output logic                      axis_bresp_ready,
    output logic [REG_ADDR_WIDTH-1:0] axis_raddr,
    output logic                      axis_raddr_valid,
    input  logic                      axis_raddr_ready,
    input  logic [REG_DATA_WIDTH-1:0] axis_rdata,
    input  logic                      axis_rdata_valid,
    output logic                      axis_rdata_ready,
    input  logic [1:0]                axis_rresp
);

    state_t                    state_q;
    logic [REG_ADDR_WIDTH-1:0] addr_q;
    logic [REG_DATA_WIDTH-1:0] wdata_q;
    logic [REG_DATA_WIDTH-1:0] rdata_q;
    logic [1:0]                resp_q;
    logic                      write_q;
    logic                      waddr_valid_q;
    logic                      wdata_valid_q;
    logic                      raddr_valid_q;
    logic                      bready_q;
    logic                      rready_q;
    logic                      rsp_valid_q;
    logic                      timeout_q;

    logic w_accept;
    logic w_aw_hs;
    logic w_w_hs;
    logic w_aw_done;
    logic w_w_done;
    logic w_expire;

    assign cmd_ready = (state_q == IDLE);
    assign w_accept  = cmd_valid && cmd_ready;
    assign w_aw_hs   = waddr_valid_q && axis_waddr_ready;
    assign w_w_hs    = wdata_valid_q && axis_wdata_ready;
    // A channel is done if it already handshook earlier or handshakes this cycle.
    assign w_aw_done = !waddr_valid_q || w_aw_hs;
    assign w_w_done  = !wdata_valid_q || w_w_hs;

    deskew_axil_watchdog #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk      (clk),
        .resetn   (resetn),
        .clear_i  (w_accept),
        .en_i     (is_busy(state_q)),
        .expire_o (w_expire)
    );

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q       <= IDLE;
            addr_q        <= '0;
            wdata_q       <= '0;
            rdata_q       <= '0;
            resp_q        <= RESP_OKAY;
            write_q       <= 1'b0;
            waddr_valid_q <= 1'b0;
            wdata_valid_q <= 1'b0;
            raddr_valid_q <= 1'b0;
            bready_q      <= 1'b0;
            rready_q      <= 1'b0;
            rsp_valid_q   <= 1'b0;
            timeout_q     <= 1'b0;
        end else begin
            if (w_expire) begin
                timeout_q <= 1'b1;
            end
            case (state_q)
                IDLE: begin
                    if (cmd_valid) begin
                        timeout_q <= 1'b0;
                        addr_q    <= cmd_addr;
                        wdata_q   <= cmd_write ? cmd_wdata : '0;
                        write_q   <= cmd_write;
                        rdata_q   <= '0;
                        resp_q    <= RESP_OKAY;
                        if (cmd_write) begin
                            state_q       <= WR_REQ;
                            waddr_valid_q <= 1'b1;
                            wdata_valid_q <= 1'b1;
                        end else begin
                            state_q       <= RD_REQ;
                            raddr_valid_q <= 1'b1;
                        end
                    end
                end
                WR_REQ: begin
                    if (w_aw_hs) begin
                        waddr_valid_q <= 1'b0;
                    end
                    if (w_w_hs) begin
                        wdata_valid_q <= 1'b0;
                    end
                    if (w_aw_done && w_w_done) begin
                        state_q  <= WR_RESP;
                        bready_q <= 1'b1;
                    end
                end
                WR_RESP: begin
                    if (axis_bresp_valid) begin
                        bready_q    <= 1'b0;
                        resp_q      <= axis_bresp;
                        rsp_valid_q <= 1'b1;
                        state_q     <= RSP;
                    end
                end
                RD_REQ: begin
                    if (axis_raddr_ready) begin
                        raddr_valid_q <= 1'b0;
                        rready_q      <= 1'b1;
                        state_q       <= RD_DATA;
                    end
                end
                RD_DATA: begin
                    if (axis_rdata_valid) begin
                        rready_q    <= 1'b0;
                        rdata_q     <= axis_rdata;
                        resp_q      <= axis_rresp;
                        rsp_valid_q <= 1'b1;
                        state_q     <= RSP;
                    end
                end
                RSP: begin
                    if (rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        state_q     <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign rsp_valid        = rsp_valid_q;
    assign rsp_write        = write_q;
    assign rsp_rdata        = rdata_q;
    assign rsp_resp         = resp_q;
    assign timeout_flag     = timeout_q;
    assign axis_waddr       = addr_q;
    assign axis_waddr_valid = waddr_valid_q;
    assign axis_wdata       = wdata_q;
    assign axis_wdata_valid = wdata_valid_q;
    assign axis_bresp_ready = bready_q;
    assign axis_raddr       = addr_q;
    assign axis_raddr_valid = raddr_valid_q;
    assign axis_rdata_ready = rready_q;

endmodule

`default_nettype wire

// File: tb/tb_deskew_axil_master.sv
// ============================================================================
// Module      : tb_deskew_axil_master
// Description : Scoreboard bench for deskew_axil_master with a delay-programmable slave.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_deskew_axil_master;

    localparam int AW = 8;
    localparam int DW = 32;

    typedef struct {
        logic          w;
        logic [DW-1:0] rdata;
        logic [1:0]    resp;
    } exp_t;

    logic          clk = 1'b0;
    logic          resetn;
    logic          cmd_valid, cmd_ready, cmd_write;
    logic [AW-1:0] cmd_addr;
    logic [DW-1:0] cmd_wdata;
    logic          rsp_valid, rsp_ready, rsp_write;
    logic [DW-1:0] rsp_rdata;
    logic [1:0]    rsp_resp;
    logic          timeout_flag;
    logic [AW-1:0] axis_waddr, axis_raddr;
    logic [DW-1:0] axis_wdata, axis_rdata;
    logic          axis_waddr_valid, axis_waddr_ready;
    logic          axis_wdata_valid, axis_wdata_ready;
    logic [1:0]    axis_bresp, axis_rresp;
    logic          axis_bresp_valid, axis_bresp_ready;
    logic          axis_raddr_valid, axis_raddr_ready;
    logic          axis_rdata_valid, axis_rdata_ready;

    int errors = 0;
    int checks = 0;
    exp_t exp_q[$];
    exp_t e_pop;

    // Slave behaviour knobs
    int aw_delay = 0, w_delay = 0, b_delay = 0, ar_delay = 0, r_delay = 0;
    int aw_cnt = 0, w_cnt = 0, b_cnt = 0, ar_cnt = 0, r_cnt = 0;
    int b_hs = 0;
    logic [1:0]    bresp_v = 2'b00;
    logic [1:0]    rresp_v = 2'b00;
    logic [DW-1:0] rdata_v = '0;

    deskew_axil_master #(
        .REG_ADDR_WIDTH (AW),
        .REG_DATA_WIDTH (DW),
        .TIMEOUT_CYCLES (16)
    ) dut (
        .clk              (clk),
        .resetn           (resetn),
        .cmd_valid        (cmd_valid),
        .cmd_ready        (cmd_ready),
        .cmd_write        (cmd_write),
        .cmd_addr         (cmd_addr),
        .cmd_wdata        (cmd_wdata),
        .rsp_valid        (rsp_valid),
        .rsp_ready        (rsp_ready),
        .rsp_write        (rsp_write),
        .rsp_rdata        (rsp_rdata),
        .rsp_resp         (rsp_resp),
        .timeout_flag     (timeout_flag),
        .axis_waddr       (axis_waddr),
        .axis_waddr_valid (axis_waddr_valid),
        .axis_waddr_ready (axis_waddr_ready),
        .axis_wdata       (axis_wdata),
        .axis_wdata_valid (axis_wdata_valid),
        .axis_wdata_ready (axis_wdata_ready),
        .axis_bresp       (axis_bresp),
        .axis_bresp_valid (axis_bresp_valid),
        .axis_bresp_ready (axis_bresp_ready),
        .axis_raddr       (axis_raddr),
        .axis_raddr_valid (axis_raddr_valid),
        .axis_raddr_ready (axis_raddr_ready),
        .axis_rdata       (axis_rdata),
        .axis_rdata_valid (axis_rdata_valid),
        .axis_rdata_ready (axis_rdata_ready),
        .axis_rresp       (axis_rresp)
    );

    always #5 clk = ~clk;

    // Slave: each ready/valid appears after the programmed number of wait cycles.
    assign axis_waddr_ready = (aw_cnt >= aw_delay);
    assign axis_wdata_ready = (w_cnt >= w_delay);
    assign axis_raddr_ready = (ar_cnt >= ar_delay);
    assign axis_bresp_valid = axis_bresp_ready && (b_cnt >= b_delay);
    assign axis_rdata_valid = axis_rdata_ready && (r_cnt >= r_delay);
    assign axis_bresp       = bresp_v;
    assign axis_rresp       = rresp_v;
    assign axis_rdata       = rdata_v;

    always @(posedge clk) begin
        aw_cnt <= (axis_waddr_valid && !axis_waddr_ready) ? aw_cnt + 1 : 0;
        w_cnt  <= (axis_wdata_valid && !axis_wdata_ready) ? w_cnt + 1 : 0;
        ar_cnt <= (axis_raddr_valid && !axis_raddr_ready) ? ar_cnt + 1 : 0;
        b_cnt  <= (axis_bresp_ready && !axis_bresp_valid) ? b_cnt + 1 : 0;
        r_cnt  <= (axis_rdata_ready && !axis_rdata_valid) ? r_cnt + 1 : 0;
        if (axis_bresp_valid && axis_bresp_ready) b_hs <= b_hs + 1;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Response monitor: pops the scoreboard on every response handshake.
    always @(negedge clk) begin
        if (resetn && rsp_valid && rsp_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL rsp_unexpected: got rsp_valid=1 expected no response at %0t", $time);
            end else begin
                e_pop = exp_q.pop_front();
                check("rsp_write", 64'(rsp_write), 64'(e_pop.w));
                check("rsp_rdata", 64'(rsp_rdata), 64'(e_pop.rdata));
                check("rsp_resp",  64'(rsp_resp),  64'(e_pop.resp));
            end
        end
    end

    // Protocol watcher: a stalled master valid must hold with stable payload.
    logic          aw_stall = 1'b0, w_stall = 1'b0, ar_stall = 1'b0;
    logic [AW-1:0] aw_a, ar_a;
    logic [DW-1:0] w_d;

    always @(negedge clk) begin
        if (!resetn) begin
            aw_stall <= 1'b0;
            w_stall  <= 1'b0;
            ar_stall <= 1'b0;
        end else begin
            if (aw_stall) check("aw_hold", {axis_waddr_valid, axis_waddr}, {1'b1, aw_a});
            if (w_stall)  check("w_hold",  {axis_wdata_valid, axis_wdata}, {1'b1, w_d});
            if (ar_stall) check("ar_hold", {axis_raddr_valid, axis_raddr}, {1'b1, ar_a});
            aw_stall <= axis_waddr_valid && !axis_waddr_ready;
            w_stall  <= axis_wdata_valid && !axis_wdata_ready;
            ar_stall <= axis_raddr_valid && !axis_raddr_ready;
            aw_a     <= axis_waddr;
            w_d      <= axis_wdata;
            ar_a     <= axis_raddr;
        end
    end

    task automatic wait_idle(input string name);
        int n = 0;
        @(negedge clk);
        while (!cmd_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        check(name, 64'(cmd_ready), 64'd1);
    endtask

    // Called at a negedge while idle; returns #1 after the accepting edge.
    task automatic issue(input bit wr, input logic [AW-1:0] a, input logic [DW-1:0] d,
                         input bit expect_rsp, input logic [DW-1:0] er, input logic [1:0] eresp);
        exp_t e;
        cmd_valid = 1'b1;
        cmd_write = wr;
        cmd_addr  = a;
        cmd_wdata = d;
        if (expect_rsp) begin
            e.w = wr;
            e.rdata = er;
            e.resp = eresp;
            exp_q.push_back(e);
        end
        @(posedge clk);
        #1 cmd_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1, "bench timeout");
    end

    initial begin
        int b_before;
        int n;
        resetn    = 1'b0;
        cmd_valid = 1'b0;
        cmd_write = 1'b0;
        cmd_addr  = '0;
        cmd_wdata = '0;
        rsp_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_valids", {axis_waddr_valid, axis_wdata_valid, axis_raddr_valid,
              axis_bresp_ready, axis_rdata_ready, rsp_valid, timeout_flag}, 64'd0);
        check("reset_regs", {axis_waddr, axis_wdata, rsp_rdata, rsp_resp}, 64'd0);
        @(posedge clk);
        #1 resetn = 1'b1;
        @(negedge clk);
        check("cmd_ready_after_reset", 64'(cmd_ready), 64'd1);

        // Minimum-latency write
        issue(1'b1, 8'h04, 32'h0000_00A0, 1'b1, 32'h0, 2'b00);
        @(negedge clk);
        check("wr_t1_valids", {axis_waddr_valid, axis_wdata_valid, cmd_ready}, 3'b110);
        check("wr_t1_payload", {axis_waddr, axis_wdata}, {8'h04, 32'h0000_00A0});
        @(negedge clk);
        check("wr_t2_bready", {axis_waddr_valid, axis_wdata_valid, axis_bresp_ready}, 3'b001);
        @(negedge clk);
        check("wr_t3_rsp_valid", 64'(rsp_valid), 64'd1);
        @(negedge clk);
        check("wr_t4_cmd_ready", {cmd_ready, rsp_valid}, 2'b10);

        // Read with address wait and 5 wait cycles on R
        ar_delay = 2;
        r_delay  = 5;
        rdata_v  = 32'h0001_0000;
        issue(1'b0, 8'h08, 32'hFFFF_FFFF, 1'b1, 32'h0001_0000, 2'b00);
        @(negedge clk);
        check("rd_ar_c1", {axis_raddr_valid, axis_raddr}, {1'b1, 8'h08});
        @(negedge clk);
        check("rd_ar_c2", {axis_raddr_valid, axis_raddr}, {1'b1, 8'h08});
        wait_idle("rd_complete");
        check("rd_no_timeout", 64'(timeout_flag), 64'd0);
        ar_delay = 0;
        r_delay  = 0;

        // W accepted three cycles before AW
        aw_delay = 3;
        b_before = b_hs;
        issue(1'b1, 8'h0C, 32'h1234_5678, 1'b1, 32'h0, 2'b00);
        @(negedge clk);
        check("skew_c1", {axis_waddr_valid, axis_wdata_valid}, 2'b11);
        @(negedge clk);
        check("skew_c2", {axis_waddr_valid, axis_wdata_valid}, 2'b10);
        wait_idle("skew_complete");
        check("skew_one_b", 64'(b_hs - b_before), 64'd1);
        aw_delay = 0;

        // SLVERR with response back-pressure
        bresp_v   = 2'b10;
        rsp_ready = 1'b0;
        issue(1'b1, 8'h20, 32'hCAFE_0001, 1'b1, 32'h0, 2'b10);
        n = 0;
        @(negedge clk);
        while (!rsp_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        for (int i = 0; i < 4; i++) begin
            check("err_hold", {rsp_valid, cmd_ready, rsp_resp}, {1'b1, 1'b0, 2'b10});
            @(negedge clk);
        end
        @(posedge clk);
        #1 rsp_ready = 1'b1;
        bresp_v = 2'b00;
        wait_idle("err_complete");

        // Watchdog: AR stalls 20 cycles with a 16-cycle limit
        ar_delay = 20;
        rdata_v  = 32'hDEAD_BEEF;
        issue(1'b0, 8'h30, 32'h0, 1'b1, 32'hDEAD_BEEF, 2'b00);
        for (int k = 1; k <= 17; k++) begin
            @(negedge clk);
            if (k == 16) check("wd_before_limit", 64'(timeout_flag), 64'd0);
            if (k == 17) check("wd_at_limit", 64'(timeout_flag), 64'd1);
        end
        wait_idle("wd_complete");
        check("wd_sticky", 64'(timeout_flag), 64'd1);
        ar_delay = 0;

        // Reset during WR_RESP; the accept also clears the sticky flag
        b_delay = 10;
        issue(1'b1, 8'h10, 32'h0000_0055, 1'b0, 32'h0, 2'b00);
        @(negedge clk);
        check("wd_cleared", 64'(timeout_flag), 64'd0);
        @(negedge clk);
        check("rst_in_wr_resp", 64'(axis_bresp_ready), 64'd1);
        #1 resetn = 1'b0;
        #1 check("rst_async", {axis_waddr_valid, axis_wdata_valid, axis_raddr_valid,
                 axis_bresp_ready, axis_rdata_ready, rsp_valid, cmd_ready}, 7'b0000001);
        @(posedge clk);
        @(posedge clk);
        #1 resetn = 1'b1;
        b_delay = 0;
        repeat (5) @(negedge clk);
        check("rst_no_rsp", {rsp_valid, cmd_ready}, 2'b01);

        check("scoreboard_empty", 64'(exp_q.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
